// File: rtl/addsub_pipe.sv
// Two-stage pipelined two's-complement add/subtract unit with accumulator and flags.
// Define ADDSUB_SAT_EN to clamp o to the signed limits on overflow.
module addsub_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       ctrl,
   input  logic             acc_clr,
   output logic [WIDTH-1:0] o,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc
);

   // ctrl[1] selects the accumulator as the first operand, ctrl[0] selects subtraction.
   localparam int MSB = WIDTH - 1;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [1:0]       s1_ctrl;

   logic             advance;
   logic             acc_op;
   logic             sub_op;
   logic [WIDTH-1:0] op_x;
   logic [WIDTH-1:0] op_y;
   logic [WIDTH:0]   ext;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] res;
   logic             raw_ovf;

   // Handshake: a beat transfers on a rising edge where valid && ready on that side.
   // The whole pipe moves or holds together; ready never depends on in_valid.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   always_comb begin
      acc_op  = s1_ctrl[1];
      sub_op  = s1_ctrl[0];
      op_x    = acc_op ? acc  : s1_a;
      op_y    = acc_op ? s1_a : s1_b;
      ext     = '0;
      raw_ovf = 1'b0;
      if (sub_op) begin
         ext     = {1'b0, op_x} - {1'b0, op_y};
         raw     = ext[WIDTH-1:0];
         raw_ovf = (op_x[MSB] != op_y[MSB]) && (raw[MSB] != op_x[MSB]);
      end else begin
         ext     = {1'b0, op_x} + {1'b0, op_y};
         raw     = ext[WIDTH-1:0];
         raw_ovf = (op_x[MSB] == op_y[MSB]) && (raw[MSB] != op_x[MSB]);
      end
      res = raw;
`ifdef ADDSUB_SAT_EN
      // On overflow the true result has the sign of the first operand.
      if (raw_ovf) begin
         res = op_x[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_ctrl  <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a    <= a;
            s1_b    <= b;
            s1_ctrl <= ctrl;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o         <= '0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            o     <= res;
            carry <= ext[WIDTH];
            ovf   <= raw_ovf;
            zero  <= (raw == '0);
         end
      end
   end

   // Clear has priority over an accumulate write landing on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (acc_clr) begin
         acc <= '0;
      end else if (advance && s1_valid && acc_op) begin
         acc <= raw;
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe at WIDTH=4: transaction model plus directed literals.
// Honours ADDSUB_SAT_EN the same way as the design.
module tb_addsub_pipe;

   localparam int W = 4;
`ifdef ADDSUB_SAT_EN
   localparam int SAT = 1;
`else
   localparam int SAT = 0;
`endif

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   ctrl;
   logic         acc_clr;
   logic [W-1:0] o;
   logic         carry;
   logic         ovf;
   logic         zero;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] acc;

   int checks   = 0;
   int failures = 0;
   bit run_cmp  = 0;

   addsub_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ctrl(ctrl), .acc_clr(acc_clr),
      .o(o), .carry(carry), .ovf(ovf), .zero(zero),
      .out_valid(out_valid), .out_ready(out_ready), .acc(acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Result of one operation from plain integer arithmetic: {o, carry, ovf, zero}.
   function automatic void model_op(input int x, input int y, input bit sub,
                                    output logic [6:0] r, output logic [W-1:0] raw);
      int u, sx, sy, s, ov;
      logic [W-1:0] ov_o;
      u  = sub ? x - y : x + y;
      sx = (x > 7) ? x - 16 : x;
      sy = (y > 7) ? y - 16 : y;
      s  = sub ? sx - sy : sx + sy;
      ov = (s > 7 || s < -8) ? 1 : 0;
      raw  = W'(u & 15);
      ov_o = raw;
      if (SAT == 1 && s > 7)  ov_o = 4'd7;
      if (SAT == 1 && s < -8) ov_o = 4'd8;
      r = {ov_o, (sub ? (x < y) : (u > 15)), ov[0], (raw == 0)};
   endfunction

   // Transaction model: a beat waits in a one-deep input slot, then becomes the held result.
   logic [W-1:0] m_a, m_b, m_acc;
   logic [1:0]   m_c;
   bit           m_s1_v, m_ov;
   logic [6:0]   m_res;
   logic [6:0]   exp_q[$];

   always @(posedge clk) begin
      logic [6:0]   r;
      logic [W-1:0] raw, new_acc;
      bit           adv, acc_wr;
      int           x, y;
      if (rst) begin
         m_s1_v = 0; m_ov = 0; m_res = '0; m_acc = '0;
         exp_q.delete();
      end else begin
         adv    = !m_ov || out_ready;
         acc_wr = 0;
         new_acc = m_acc;
         if (adv) begin
            if (m_s1_v) begin
               x = m_c[1] ? int'(m_acc) : int'(m_a);
               y = m_c[1] ? int'(m_a) : int'(m_b);
               model_op(x, y, m_c[0], r, raw);
               m_res = r;
               exp_q.push_back(r);
               if (m_c[1]) begin acc_wr = 1; new_acc = raw; end
            end
            m_ov   = m_s1_v;
            m_s1_v = in_valid;
            m_a = a; m_b = b; m_c = ctrl;
         end
         if (acc_clr) m_acc = '0;
         else if (acc_wr) m_acc = new_acc;
      end
   end

   always @(negedge clk) begin
      logic [6:0] f;
      if (run_cmp) begin
         chk("in_ready", in_ready, (!m_ov || out_ready) ? 1 : 0);
         chk("out_valid", out_valid, m_ov ? 1 : 0);
         chk("acc", acc, m_acc);
         if (m_ov) begin
            chk("o", o, m_res[6:3]);
            chk("carry", carry, m_res[2]);
            chk("ovf", ovf, m_res[1]);
            chk("zero", zero, m_res[0]);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL order: unexpected result o=%0d with empty queue", o);
            end else begin
               f = exp_q.pop_front();
               chk("order_o", o, f[6:3]);
            end
         end
      end
   end

   task automatic send(input logic [1:0] c, input logic [W-1:0] av, input logic [W-1:0] bv);
      in_valid = 1'b1; ctrl = c; a = av; b = bv;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  nacc;
      bit  ok;
      logic [W-1:0] bp_a;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctrl = 2'd0;
      acc_clr = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      run_cmp = 1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_o", o, 0);
      chk("rst_flags", {carry, ovf, zero}, 0);
      chk("rst_acc", acc, 0);
      rst = 1'b0;
      idle(1);

      // ADD 3+4 then SUB 2-5
      send(2'd0, 4'd3, 4'd4);
      chk("lat_not_yet", out_valid, 0);
      send(2'd1, 4'd2, 4'd5);
      chk("add_valid", out_valid, 1);
      chk("add_o", o, 7);
      chk("add_cv", {carry, ovf}, 0);
      idle(1);
      chk("sub_o", o, 13);
      chk("sub_carry", carry, 1);
      chk("sub_ovf", ovf, 0);
      idle(2);

      // Signed overflow both directions
      send(2'd0, 4'd7, 4'd1);
      idle(1);
      chk("ovf_add_flag", ovf, 1);
      chk("ovf_add_o", o, SAT ? 7 : 8);
      send(2'd1, 4'd8, 4'd1);
      idle(1);
      chk("ovf_sub_flag", ovf, 1);
      chk("ovf_sub_o", o, SAT ? 8 : 7);
      idle(2);

      // Accumulate chain 5, +6, -2
      send(2'd2, 4'd5, 4'd0);
      send(2'd2, 4'd6, 4'd0);
      chk("acc1_o", o, 5);
      chk("acc1_acc", acc, 5);
      send(2'd3, 4'd2, 4'd0);
      chk("acc2_o", o, SAT ? 7 : 11);
      chk("acc2_acc", acc, 11);
      idle(1);
      chk("acc3_o", o, 9);
      chk("acc3_acc", acc, 9);

      // ACC_ADD 7 with a clear on the edge its result is registered
      send(2'd2, 4'd7, 4'd0);
      in_valid = 1'b0; acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      chk("clr_o", o, 0);
      chk("clr_zero", zero, 1);
      chk("clr_carry", carry, 1);
      chk("clr_acc", acc, 0);
      idle(2);

      // Backpressure: out_ready low for 5 cycles with in_valid held
      out_ready = 1'b0; nacc = 0; bp_a = 4'd1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; ctrl = 2'd0; a = bp_a; b = 4'd1;
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         if (ok) begin nacc++; bp_a = bp_a + 4'd1; end
      end
      chk("bp_accepted", nacc, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_held_o", o, 2);
      out_ready = 1'b1;
      idle(4);

      // Mixed traffic with random backpressure and occasional clears
      in_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 80; i++) begin
         if (!in_valid || ok) begin
            in_valid = ($urandom_range(0, 3) != 0);
            ctrl = 2'($urandom_range(0, 3));
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
         end
         out_ready = ($urandom_range(0, 2) != 0);
         acc_clr = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         ok = in_valid && in_ready;
         @(posedge clk); #1;
      end
      acc_clr = 1'b0; out_ready = 1'b1;
      idle(3);

      // Reset with both stages occupied and the output stalled
      send(2'd2, 4'd3, 4'd0);
      send(2'd2, 4'd3, 4'd0);
      out_ready = 1'b0;
      in_valid = 1'b1; ctrl = 2'd0; a = 4'd1; b = 4'd1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_acc", acc, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      rst = 1'b0; out_ready = 1'b1;
      idle(4);

      run_cmp = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
